// File: rtl/mips_mem_pkg.sv
// Shared encodings and decode helpers for the MEM-stage access unit.
package mips_mem_pkg;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LH  = 3'd1,
    OP_LHU = 3'd2,
    OP_LB  = 3'd3,
    OP_LBU = 3'd4,
    OP_SW  = 3'd5,
    OP_SH  = 3'd6,
    OP_SB  = 3'd7
  } mem_op_e;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_e;

  function automatic logic is_load(input logic [2:0] op);
    return op <= 3'd4;
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    return op >= 3'd5;
  endfunction

  function automatic logic is_subword_store(input logic [2:0] op);
    return (op == OP_SH) || (op == OP_SB);
  endfunction

  function automatic logic is_aligned(input logic [2:0] op, input logic [1:0] lo);
    logic ok;
    case (mem_op_e'(op))
      OP_LW, OP_SW:         ok = (lo == 2'b00);
      OP_LH, OP_LHU, OP_SH: ok = ~lo[0];
      default:              ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and data_memory signals of the MEM-stage access unit.
interface mem_access_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              misalign;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // Pipeline and memory side together.
  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, misalign,
    input  mem_addr, mem_read, mem_write, mem_wdata
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, misalign,
    output mem_addr, mem_read, mem_write, mem_wdata
  );
endinterface

// File: rtl/mem_lane_ctl.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module mem_lane_ctl
  import mips_mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [2:0]  op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [31:0] byte_word;
  logic [31:0] half_word;
  logic [7:0]  lb;
  logic [15:0] lh;

  always_comb begin
    // Shift that brings the addressed lane down to bit 0.
    byte_sh   = BIG_ENDIAN ? (5'd24 - {byte_off, 3'b000}) : {byte_off, 3'b000};
    half_sh   = (BIG_ENDIAN ^ byte_off[1]) ? 5'd16 : 5'd0;
    byte_word = rdata >> byte_sh;
    half_word = rdata >> half_sh;
    lb        = byte_word[7:0];
    lh        = half_word[15:0];

    load_data  = rdata;
    store_word = wdata;
    case (mem_op_e'(op))
      OP_LH:   load_data = {{16{lh[15]}}, lh};
      OP_LHU:  load_data = {16'h0000, lh};
      OP_LB:   load_data = {{24{lb[7]}}, lb};
      OP_LBU:  load_data = {24'h000000, lb};
      OP_SH:   store_word = (rdata & ~(32'h0000_FFFF << half_sh))
                          | ({16'h0000, wdata[15:0]} << half_sh);
      OP_SB:   store_word = (rdata & ~(32'h0000_00FF << byte_sh))
                          | ({24'h000000, wdata[7:0]} << byte_sh);
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage front end: word accesses, lane extraction, read-modify-write sub-word stores.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_access_unit_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       merged_q;
  logic              resp_valid_q;
  logic [31:0]       resp_rdata_q;
  logic              misalign_q;

  logic              ready;
  logic              accept;
  logic              aligned;
  logic              load_op;
  logic              sub_store;
  logic [31:0]       load_data;
  logic [31:0]       store_word;

  assign ready     = (state_q == IDLE);
  assign accept    = bus.req_valid & ready;
  assign aligned   = is_aligned(bus.req_op, bus.req_addr[1:0]);
  assign load_op   = is_load(bus.req_op);
  assign sub_store = is_subword_store(bus.req_op);

  mem_lane_ctl #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_lane (
    .op         (bus.req_op),
    .byte_off   (bus.req_addr[1:0]),
    .rdata      (bus.mem_rdata),
    .wdata      (bus.req_wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // State register; reset mid-RMW drops the pending store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && aligned && sub_store) state_d = RMW_WR;
      RMW_WR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_addr  = bus.req_addr;
    bus.mem_wdata = bus.req_wdata;
    unique case (state_q)
      IDLE: begin
        if (accept && aligned) begin
          if (load_op || sub_store) bus.mem_read  = 1'b1;
          else                      bus.mem_write = 1'b1;
        end
      end
      RMW_WR: begin
        bus.mem_write = 1'b1;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = merged_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      merged_q <= '0;
    end else if (accept && aligned && sub_store) begin
      addr_q   <= bus.req_addr;
      merged_q <= store_word;
    end
  end

  // Sub-word stores respond after their write phase, not at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      misalign_q   <= 1'b0;
    end else begin
      resp_valid_q <= (state_q == RMW_WR) | (accept & ~(aligned & sub_store));
      misalign_q   <= accept & ~aligned;
      resp_rdata_q <= (accept && aligned && load_op) ? load_data : 32'h0;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.misalign   = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word-addressed memory.
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  mem_access_unit_if #(.ADDR_W(32)) bus ();

  mem_access_unit #(
    .ADDR_W     (32),
    .BIG_ENDIAN (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem_arr [64];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  always @(posedge clk) begin
    if (pre_we) mem_arr[pre_idx] <= pre_data;
    else if (bus.mem_write) mem_arr[bus.mem_addr[7:2]] <= bus.mem_wdata;
  end
  assign bus.mem_rdata = mem_arr[bus.mem_addr[7:2]];

  task automatic set_req(input mem_op_e op, input logic [31:0] addr, input logic [31:0] wd);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
  endtask

  task automatic set_idle();
    bus.req_valid = 1'b0;
    bus.req_op    = OP_LW;
    bus.req_addr  = 32'h0;
    bus.req_wdata = 32'h0;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_data = data;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp_valid got %0b want 0", bus.resp_valid); end
    tests++; if (bus.resp_rdata !== 32'h0) begin fails++; $display("FAIL rst_resp_rdata got %h want 0", bus.resp_rdata); end
    tests++; if (bus.misalign !== 1'b0) begin fails++; $display("FAIL rst_misalign got %0b want 0", bus.misalign); end
    tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL rst_req_ready got %0b want 1", bus.req_ready); end
    tests++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
      fails++; $display("FAIL rst_mem_en got rd=%0b wr=%0b want 0/0", bus.mem_read, bus.mem_write);
    end
  endtask

  // LB, LBU, LH, LHU, LW back-to-back on word[4]=0x8899AABB.
  task automatic test_loads();
    mem_op_e     ops [5] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    logic [31:0] adr [5] = '{32'h11, 32'h11, 32'h12, 32'h10, 32'h10};
    logic [31:0] exp [5] = '{32'hFFFFFF99, 32'h00000099, 32'hFFFFAABB, 32'h00008899, 32'h8899AABB};
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        tests++; if (bus.resp_valid !== 1'b1) begin fails++; $display("FAIL load%0d_valid got %0b want 1", i-1, bus.resp_valid); end
        tests++; if (bus.resp_rdata !== exp[i-1]) begin fails++; $display("FAIL load%0d_rdata got %h want %h", i-1, bus.resp_rdata, exp[i-1]); end
        tests++; if (bus.misalign !== 1'b0) begin fails++; $display("FAIL load%0d_misalign got %0b want 0", i-1, bus.misalign); end
      end
      if (i < 5) begin
        set_req(ops[i], adr[i], 32'h0);
        #1;
        tests++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== adr[i]) begin
          fails++; $display("FAIL load%0d_memrd got rd=%0b addr=%h want 1 %h", i, bus.mem_read, bus.mem_addr, adr[i]);
        end
      end else begin
        set_idle();
      end
    end
    @(negedge clk);
    tests++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL idle_valid got %0b want 0", bus.resp_valid); end
  endtask

  task automatic test_sub_store();
    @(negedge clk);
    set_req(OP_SB, 32'h13, 32'h000000CC);
    #1;
    tests++; if (bus.req_ready !== 1'b1 || bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0) begin
      fails++; $display("FAIL sb_rd_phase got rdy=%0b rd=%0b wr=%0b want 1 1 0", bus.req_ready, bus.mem_read, bus.mem_write);
    end
    @(negedge clk);
    set_idle();
    #1;
    tests++; if (bus.req_ready !== 1'b0 || bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin
      fails++; $display("FAIL sb_wr_phase got rdy=%0b wr=%0b rd=%0b want 0 1 0", bus.req_ready, bus.mem_write, bus.mem_read);
    end
    tests++; if (bus.mem_wdata !== 32'h8899AACC || bus.mem_addr !== 32'h13) begin
      fails++; $display("FAIL sb_wdata got %h @%h want 8899aacc @13", bus.mem_wdata, bus.mem_addr);
    end
    tests++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL sb_early_valid got %0b want 0", bus.resp_valid); end
    @(negedge clk);
    tests++; if (bus.resp_valid !== 1'b1 || bus.misalign !== 1'b0 || bus.resp_rdata !== 32'h0) begin
      fails++; $display("FAIL sb_resp got v=%0b m=%0b d=%h want 1 0 0", bus.resp_valid, bus.misalign, bus.resp_rdata);
    end
    tests++; if (bus.req_ready !== 1'b1 || bus.mem_write !== 1'b0) begin
      fails++; $display("FAIL sb_done got rdy=%0b wr=%0b want 1 0", bus.req_ready, bus.mem_write);
    end
    set_req(OP_LW, 32'h10, 32'h0);
    @(negedge clk);
    set_idle();
    tests++; if (bus.resp_rdata !== 32'h8899AACC) begin fails++; $display("FAIL sb_readback got %h want 8899aacc", bus.resp_rdata); end
  endtask

  task automatic test_misalign();
    @(negedge clk);
    set_req(OP_SH, 32'h11, 32'h0000BEEF);
    #1;
    tests++; if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0) begin
      fails++; $display("FAIL sh_mis_en got rd=%0b wr=%0b want 0 0", bus.mem_read, bus.mem_write);
    end
    @(negedge clk);
    tests++; if (bus.resp_valid !== 1'b1 || bus.misalign !== 1'b1 || bus.resp_rdata !== 32'h0) begin
      fails++; $display("FAIL sh_mis_resp got v=%0b m=%0b d=%h want 1 1 0", bus.resp_valid, bus.misalign, bus.resp_rdata);
    end
    tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL sh_mis_ready got %0b want 1", bus.req_ready); end
    set_req(OP_SW, 32'h12, 32'hDEADBEEF);
    #1;
    tests++; if (bus.mem_write !== 1'b0) begin fails++; $display("FAIL sw_mis_wr got %0b want 0", bus.mem_write); end
    @(negedge clk);
    set_idle();
    tests++; if (bus.resp_valid !== 1'b1 || bus.misalign !== 1'b1) begin
      fails++; $display("FAIL sw_mis_resp got v=%0b m=%0b want 1 1", bus.resp_valid, bus.misalign);
    end
    tests++; if (mem_arr[4] !== 32'h8899AACC) begin fails++; $display("FAIL mis_mem got %h want 8899aacc", mem_arr[4]); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    set_req(OP_SW, 32'h20, 32'h12345678);
    #1;
    tests++; if (bus.mem_write !== 1'b1 || bus.mem_wdata !== 32'h12345678) begin
      fails++; $display("FAIL sw_wr got wr=%0b d=%h want 1 12345678", bus.mem_write, bus.mem_wdata);
    end
    @(negedge clk);
    tests++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h0) begin
      fails++; $display("FAIL sw_resp got v=%0b d=%h want 1 0", bus.resp_valid, bus.resp_rdata);
    end
    set_req(OP_LW, 32'h20, 32'h0);
    @(negedge clk);
    tests++; if (bus.resp_rdata !== 32'h12345678) begin fails++; $display("FAIL sw_lw got %h want 12345678", bus.resp_rdata); end
    set_req(OP_SB, 32'h21, 32'h000000AB);
    @(negedge clk);
    set_req(OP_LB, 32'h21, 32'h0);
    #1;
    tests++; if (bus.req_ready !== 1'b0 || bus.mem_read !== 1'b0) begin
      fails++; $display("FAIL lb_held got rdy=%0b rd=%0b want 0 0", bus.req_ready, bus.mem_read);
    end
    @(negedge clk);
    tests++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h0) begin
      fails++; $display("FAIL sb2_resp got v=%0b d=%h want 1 0", bus.resp_valid, bus.resp_rdata);
    end
    #1;
    tests++; if (bus.mem_read !== 1'b1) begin fails++; $display("FAIL lb_accept got rd=%0b want 1", bus.mem_read); end
    @(negedge clk);
    set_idle();
    tests++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hFFFFFFAB) begin
      fails++; $display("FAIL lb_merged got v=%0b d=%h want 1 ffffffab", bus.resp_valid, bus.resp_rdata);
    end
  endtask

  task automatic test_reset_in_rmw();
    @(negedge clk);
    set_req(OP_SB, 32'h22, 32'h00000011);
    @(negedge clk);
    set_idle();
    #1;
    tests++; if (bus.mem_write !== 1'b1) begin fails++; $display("FAIL rmw_wr_before got %0b want 1", bus.mem_write); end
    #1 rst_n = 1'b0;
    #1;
    tests++; if (bus.mem_write !== 1'b0) begin fails++; $display("FAIL rmw_async_drop got %0b want 0", bus.mem_write); end
    @(negedge clk);
    tests++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      fails++; $display("FAIL rmw_in_rst got v=%0b rdy=%0b want 0 1", bus.resp_valid, bus.req_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      fails++; $display("FAIL rmw_after_rst got v=%0b rdy=%0b want 0 1", bus.resp_valid, bus.req_ready);
    end
    tests++; if (mem_arr[8] !== 32'h12AB5678) begin fails++; $display("FAIL rmw_mem got %h want 12ab5678", mem_arr[8]); end
  endtask

  initial begin
    set_idle();
    test_reset();
    preload(6'd4, 32'h8899AABB);
    @(negedge clk);
    rst_n = 1'b1;
    test_loads();
    test_sub_store();
    test_misalign();
    test_back_to_back();
    test_reset_in_rmw();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
